// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-width sizing, syndrome calculation and parity-position test.
package hamming_pkg;

    localparam int unsigned MAX_BLOCK_WIDTH = 64;
    localparam int unsigned SYN_WIDTH       = 8;

    // Smallest p with 2**p >= data_width + p + 1.
    function automatic int unsigned hamming_parity_width(input int unsigned data_width);
        int unsigned p;
        p = 1;
        while ((32'd1 << p) < (data_width + p + 1)) p++;
        return p;
    endfunction

    // XOR of the 1-based positions of all set bits within the first 'width' bits.
    function automatic logic [SYN_WIDTH-1:0] hamming_syndrome(
        input logic [MAX_BLOCK_WIDTH-1:0] block,
        input int unsigned                width
    );
        logic [SYN_WIDTH-1:0]       syn;
        logic [MAX_BLOCK_WIDTH-1:0] bits;
        syn  = '0;
        bits = block;
        for (int unsigned p = 1; p <= MAX_BLOCK_WIDTH; p++) begin
            if (bits[0] && (p <= width)) syn ^= SYN_WIDTH'(p);
            bits = bits >> 1;
        end
        return syn;
    endfunction

    function automatic bit is_parity_position(input int unsigned p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

endpackage

// File: rtl/hamming_block_unpacker.sv
// Splits a Hamming block into payload (non-power-of-two positions, ascending) and parity code.
module hamming_block_unpacker
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned PARITY_WIDTH = 3
) (
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] i_block,
    output logic [DATA_WIDTH-1:0]              o_data_c,
    output logic [PARITY_WIDTH-1:0]            o_code_c
);

    localparam int unsigned BLOCK_WIDTH = DATA_WIDTH + PARITY_WIDTH;

    // Position p holds parity bit log2(p) or data bit p-1-(number of powers of two <= p).
    for (genvar p = 1; p <= BLOCK_WIDTH; p++) begin : g_pos
        if (is_parity_position(p)) begin : g_par
            assign o_code_c[$clog2(p)] = i_block[p-1];
        end else begin : g_dat
            assign o_data_c[p - 1 - $clog2(p + 1)] = i_block[p-1];
        end
    end

endmodule

// File: rtl/hamming_stream_decoder.sv
// Two-stage valid/ready Hamming decoder: syndrome in stage 1, correction and unpack in stage 2.
// Error counters are built only when HAMMING_DECODER_COUNTERS_EN is defined.
module hamming_stream_decoder
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 4,
    parameter  int unsigned COUNTER_WIDTH = 16,
    localparam int unsigned PARITY_WIDTH  = hamming_parity_width(DATA_WIDTH),
    localparam int unsigned BLOCK_WIDTH   = DATA_WIDTH + PARITY_WIDTH
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BLOCK_WIDTH-1:0]   in_block,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [PARITY_WIDTH-1:0]  out_syndrome,
    output logic                     out_corrected,
    output logic                     out_uncorrectable,
    input  logic                     counters_clear,
    output logic [COUNTER_WIDTH-1:0] corrected_count,
    output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

    logic                    r_s1_valid;
    logic [BLOCK_WIDTH-1:0]  r_s1_block;
    logic [PARITY_WIDTH-1:0] r_s1_syndrome;
    logic                    r_s2_valid;
    logic [DATA_WIDTH-1:0]   r_s2_data;
    logic [PARITY_WIDTH-1:0] r_s2_syndrome;
    logic                    r_s2_corrected;
    logic                    r_s2_uncorr;

    logic                    w_s1_ready;
    logic                    w_s2_ready;
    logic                    w_out_hs;
    logic [PARITY_WIDTH-1:0] w_in_syndrome;
    logic                    w_s1_correctable;
    logic                    w_s1_uncorr;
    logic [BLOCK_WIDTH-1:0]  w_flip_mask;
    logic [BLOCK_WIDTH-1:0]  w_fixed_block;
    logic [DATA_WIDTH-1:0]   w_fixed_data;
    logic [PARITY_WIDTH-1:0] w_unused_code;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_out_hs   = r_s2_valid && out_ready;
    assign in_ready   = w_s1_ready;

    assign w_in_syndrome = PARITY_WIDTH'(hamming_syndrome(MAX_BLOCK_WIDTH'(in_block), BLOCK_WIDTH));

    // Syndromes beyond the block length only arise from shortened codes; pass those through.
    assign w_s1_correctable = (r_s1_syndrome != '0) && (r_s1_syndrome <= PARITY_WIDTH'(BLOCK_WIDTH));
    assign w_s1_uncorr      = r_s1_syndrome > PARITY_WIDTH'(BLOCK_WIDTH);
    assign w_flip_mask      = w_s1_correctable ?
                              (BLOCK_WIDTH'(1) << (r_s1_syndrome - PARITY_WIDTH'(1))) : '0;
    assign w_fixed_block    = r_s1_block ^ w_flip_mask;

    hamming_block_unpacker #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PARITY_WIDTH (PARITY_WIDTH)
    ) u_unpacker (
        .i_block  (w_fixed_block),
        .o_data_c (w_fixed_data),
        .o_code_c (w_unused_code)
    );

    // Stage 1: received block and its syndrome.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid    <= 1'b0;
            r_s1_block    <= '0;
            r_s1_syndrome <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_block    <= in_block;
                r_s1_syndrome <= w_in_syndrome;
            end
        end
    end

    // Stage 2: corrected payload and flags; held while the sink stalls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s2_valid     <= 1'b0;
            r_s2_data      <= '0;
            r_s2_syndrome  <= '0;
            r_s2_corrected <= 1'b0;
            r_s2_uncorr    <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data      <= w_fixed_data;
                r_s2_syndrome  <= r_s1_syndrome;
                r_s2_corrected <= w_s1_correctable;
                r_s2_uncorr    <= w_s1_uncorr;
            end
        end
    end

    assign out_valid         = r_s2_valid;
    assign out_data          = r_s2_data;
    assign out_syndrome      = r_s2_syndrome;
    assign out_corrected     = r_s2_corrected;
    assign out_uncorrectable = r_s2_uncorr;

`ifdef HAMMING_DECODER_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] r_corrected_count;
    logic [COUNTER_WIDTH-1:0] r_uncorr_count;

    // Saturating event counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_corrected_count <= '0;
            r_uncorr_count    <= '0;
        end else if (counters_clear) begin
            r_corrected_count <= '0;
            r_uncorr_count    <= '0;
        end else if (w_out_hs) begin
            if (r_s2_corrected && (r_corrected_count != '1))
                r_corrected_count <= r_corrected_count + COUNTER_WIDTH'(1);
            if (r_s2_uncorr && (r_uncorr_count != '1))
                r_uncorr_count <= r_uncorr_count + COUNTER_WIDTH'(1);
        end
    end

    assign corrected_count     = r_corrected_count;
    assign uncorrectable_count = r_uncorr_count;
`else
    logic w_unused_ctrl;

    assign w_unused_ctrl       = counters_clear ^ w_out_hs;
    assign corrected_count     = '0;
    assign uncorrectable_count = '0;
`endif

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Scoreboard bench for hamming_stream_decoder: a 4-bit instance and an 8-bit / 2-bit-counter instance.
module tb_hamming_stream_decoder;

    localparam int unsigned AD = 4, AP = 3, AB = 7, ACW = 16;
    localparam int unsigned BD = 8, BP = 4, BB = 12, BCW = 2;
`ifdef HAMMING_DECODER_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           a_resetn = 1'b0, a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [AB-1:0]  a_in_block = '0;
    logic [AD-1:0]  a_out_data;
    logic [AP-1:0]  a_out_syn;
    logic           a_out_cor, a_out_unc, a_clear = 1'b0;
    logic [ACW-1:0] a_ccnt, a_ucnt;

    logic           b_resetn = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [BB-1:0]  b_in_block = '0;
    logic [BD-1:0]  b_out_data;
    logic [BP-1:0]  b_out_syn;
    logic           b_out_cor, b_out_unc, b_clear = 1'b0;
    logic [BCW-1:0] b_ccnt, b_ucnt;

    int   n_tests = 0, n_fail = 0;
    exp_t q_a[$], q_b[$];
    int   occ_a = 0, occ_b = 0;
    logic [ACW-1:0] m_ca = '0, m_ua = '0;
    logic [BCW-1:0] m_cb = '0, m_ub = '0;
    logic rand_phase = 1'b0, a_ready_fix = 1'b1;

    hamming_stream_decoder #(.DATA_WIDTH(AD), .COUNTER_WIDTH(ACW)) u_dut_a (
        .clock(clock), .resetn(a_resetn), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_block(a_in_block), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_syndrome(a_out_syn), .out_corrected(a_out_cor),
        .out_uncorrectable(a_out_unc), .counters_clear(a_clear),
        .corrected_count(a_ccnt), .uncorrectable_count(a_ucnt)
    );

    hamming_stream_decoder #(.DATA_WIDTH(BD), .COUNTER_WIDTH(BCW)) u_dut_b (
        .clock(clock), .resetn(b_resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_block(b_in_block), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_syndrome(b_out_syn), .out_corrected(b_out_cor),
        .out_uncorrectable(b_out_unc), .counters_clear(b_clear),
        .corrected_count(b_ccnt), .uncorrectable_count(b_ucnt)
    );

    // Hand-computed 4-bit vectors: block, expected data, syndrome, corrected flag.
    logic [AB-1:0] tbl_blk [11] = '{7'h55, 7'h45, 7'h54, 7'h00, 7'h7F, 7'h33, 7'h13, 7'h77, 7'h40, 7'h02, 7'h51};
    logic [AD-1:0] tbl_dat [11] = '{4'hB,  4'hB,  4'hB,  4'h0,  4'hF,  4'h6,  4'h6,  4'hF,  4'h0,  4'h0,  4'hB};
    logic [AP-1:0] tbl_syn [11] = '{3'd0,  3'd5,  3'd1,  3'd0,  3'd0,  3'd0,  3'd6,  3'd4,  3'd7,  3'd2,  3'd3};
    logic          tbl_cor [11] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Sink ready: random during the stress phase, otherwise the directed value.
    initial begin : ready_gen
        forever begin
            @(posedge clock);
            #2;
            a_out_ready = rand_phase ? 1'($urandom_range(0, 1)) : a_ready_fix;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_a(input logic [AB-1:0] blk, input logic [AD-1:0] d, input logic [AP-1:0] s, input logic c);
        int g;
        g = 0;
        a_in_valid = 1'b1;
        a_in_block = blk;
        @(negedge clock);
        while (!a_in_ready && g < 500) begin @(negedge clock); g++; end
        if (g >= 500) begin
            n_tests++; n_fail++;
            $display("FAIL a_accept_timeout: in_ready stuck 0, required 1");
        end else q_a.push_back('{data: 8'(d), syn: 4'(s), corr: c, unc: 1'b0});
        @(posedge clock); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [BB-1:0] blk, input logic [BD-1:0] d, input logic [BP-1:0] s,
                          input logic c, input logic u);
        int g;
        g = 0;
        b_in_valid = 1'b1;
        b_in_block = blk;
        @(negedge clock);
        while (!b_in_ready && g < 500) begin @(negedge clock); g++; end
        if (g >= 500) begin
            n_tests++; n_fail++;
            $display("FAIL b_accept_timeout: in_ready stuck 0, required 1");
        end else q_b.push_back('{data: d, syn: s, corr: c, unc: u});
        @(posedge clock); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int g;
        g = 0;
        while (q_a.size() != 0 && g < 2000) begin @(posedge clock); g++; end
        if (q_a.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL a_drain_timeout: %0d words outstanding, required 0", q_a.size());
            q_a.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic drain_b();
        int g;
        g = 0;
        while (q_b.size() != 0 && g < 2000) begin @(posedge clock); g++; end
        if (q_b.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL b_drain_timeout: %0d words outstanding, required 0", q_b.size());
            q_b.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Monitor A: handshake rule, hold stability, scoreboard order and counter model.
    initial begin : mon_a
        logic hold;
        logic [AD-1:0] h_data;
        logic [AP-1:0] h_syn;
        logic h_cor;
        exp_t e;
        hold = 1'b0; h_data = '0; h_syn = '0; h_cor = 1'b0;
        forever begin
            @(negedge clock);
            if (!a_resetn) begin
                occ_a = 0; m_ca = '0; m_ua = '0; hold = 1'b0;
            end else begin
                check("a_in_ready", 32'(a_in_ready), 32'(!(occ_a == 2 && !a_out_ready)));
                check("a_corrected_count", 32'(a_ccnt), 32'(m_ca));
                check("a_uncorrectable_count", 32'(a_ucnt), 32'(m_ua));
                if (hold) begin
                    check("a_hold_valid", 32'(a_out_valid), 32'd1);
                    check("a_hold_data", 32'(a_out_data), 32'(h_data));
                    check("a_hold_syndrome", 32'(a_out_syn), 32'(h_syn));
                    check("a_hold_corrected", 32'(a_out_cor), 32'(h_cor));
                end
                if (a_out_valid && a_out_ready) begin
                    if (q_a.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL a_spurious_output: data %0h presented, required no output", a_out_data);
                    end else begin
                        e = q_a.pop_front();
                        check("a_data", 32'(a_out_data), 32'(e.data));
                        check("a_syndrome", 32'(a_out_syn), 32'(e.syn));
                        check("a_corrected", 32'(a_out_cor), 32'(e.corr));
                        check("a_uncorrectable", 32'(a_out_unc), 32'(e.unc));
                        if (CNT_EN && !a_clear && e.corr && m_ca != '1) m_ca = m_ca + ACW'(1);
                        if (CNT_EN && !a_clear && e.unc && m_ua != '1) m_ua = m_ua + ACW'(1);
                    end
                end
                if (a_clear) begin m_ca = '0; m_ua = '0; end
                occ_a = occ_a + int'(a_in_valid && a_in_ready) - int'(a_out_valid && a_out_ready);
                hold   = a_out_valid && !a_out_ready;
                h_data = a_out_data; h_syn = a_out_syn; h_cor = a_out_cor;
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clock);
            if (!b_resetn) begin
                occ_b = 0; m_cb = '0; m_ub = '0;
            end else begin
                check("b_in_ready", 32'(b_in_ready), 32'(!(occ_b == 2 && !b_out_ready)));
                check("b_corrected_count", 32'(b_ccnt), 32'(m_cb));
                check("b_uncorrectable_count", 32'(b_ucnt), 32'(m_ub));
                if (b_out_valid && b_out_ready) begin
                    if (q_b.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL b_spurious_output: data %0h presented, required no output", b_out_data);
                    end else begin
                        e = q_b.pop_front();
                        check("b_data", 32'(b_out_data), 32'(e.data));
                        check("b_syndrome", 32'(b_out_syn), 32'(e.syn));
                        check("b_corrected", 32'(b_out_cor), 32'(e.corr));
                        check("b_uncorrectable", 32'(b_out_unc), 32'(e.unc));
                        if (CNT_EN && !b_clear && e.corr && m_cb != '1) m_cb = m_cb + BCW'(1);
                        if (CNT_EN && !b_clear && e.unc && m_ub != '1) m_ub = m_ub + BCW'(1);
                    end
                end
                if (b_clear) begin m_cb = '0; m_ub = '0; end
                occ_b = occ_b + int'(b_in_valid && b_in_ready) - int'(b_out_valid && b_out_ready);
            end
        end
    end

    initial begin : main
        int g;
        repeat (3) @(posedge clock);
        #1;
        check("a_reset_out_valid", 32'(a_out_valid), 32'd0);
        check("a_reset_out_data", 32'(a_out_data), 32'd0);
        check("a_reset_flags", 32'({a_out_syn, a_out_cor, a_out_unc}), 32'd0);
        check("b_reset_out_valid", 32'(b_out_valid), 32'd0);
        check("b_reset_counts", 32'({b_ccnt, b_ucnt}), 32'd0);
        a_resetn = 1'b1;
        b_resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Clean block with two-cycle latency.
        send_a(7'h55, 4'hB, 3'd0, 1'b0);
        @(negedge clock);
        check("a_latency_cycle1_valid", 32'(a_out_valid), 32'd0);
        @(negedge clock);
        check("a_latency_cycle2_valid", 32'(a_out_valid), 32'd1);
        drain_a();

        send_a(7'h45, 4'hB, 3'd5, 1'b1);
        drain_a();
        check("a_corrected_count_after_pos5", 32'(a_ccnt), CNT_EN ? 32'd1 : 32'd0);
        send_a(7'h54, 4'hB, 3'd1, 1'b1);
        drain_a();

        // Back-to-back stream with random sink stalls.
        rand_phase = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 11; i++)
                send_a(tbl_blk[i], tbl_dat[i], tbl_syn[i], tbl_cor[i]);
        rand_phase = 1'b0;
        drain_a();

        // 8-bit shortened code: clean, single error, and a double error beyond the block.
        b_out_ready = 1'b1;
        send_b(12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
        send_b(12'hB27, 8'hA5, 4'd9, 1'b1, 1'b0);
        send_b(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
        drain_b();
        check("b_uncorrectable_count_one", 32'(b_ucnt), CNT_EN ? 32'd1 : 32'd0);

        for (int i = 0; i < 4; i++) send_b(12'hB27, 8'hA5, 4'd9, 1'b1, 1'b0);
        drain_b();
        check("b_corrected_count_saturated", 32'(b_ccnt), CNT_EN ? 32'd3 : 32'd0);

        // Clear lands on the same edge as a corrected-block handshake.
        b_out_ready = 1'b0;
        send_b(12'hB27, 8'hA5, 4'd9, 1'b1, 1'b0);
        g = 0;
        while (!b_out_valid && g < 100) begin @(negedge clock); g++; end
        check("b_wait_out_valid", 32'(b_out_valid), 32'd1);
        @(posedge clock); #1;
        b_clear = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clock); #1;
        b_clear = 1'b0;
        drain_b();
        check("b_clear_wins_corrected", 32'(b_ccnt), 32'd0);
        check("b_clear_wins_uncorrectable", 32'(b_ucnt), 32'd0);

        send_b(12'hB27, 8'hA5, 4'd9, 1'b1, 1'b0);
        drain_b();
        check("b_count_before_reset", 32'(b_ccnt), CNT_EN ? 32'd1 : 32'd0);

        // Fill both stages, then reset asynchronously mid-stream.
        b_out_ready = 1'b0;
        send_b(12'hB27, 8'hA5, 4'd9, 1'b1, 1'b0);
        send_b(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
        @(negedge clock);
        check("b_full_in_ready", 32'(b_in_ready), 32'd0);
        #1;
        b_resetn = 1'b0;
        #1;
        check("b_midreset_out_valid", 32'(b_out_valid), 32'd0);
        check("b_midreset_out_data", 32'(b_out_data), 32'd0);
        check("b_midreset_flags", 32'({b_out_syn, b_out_cor, b_out_unc}), 32'd0);
        check("b_midreset_counts", 32'({b_ccnt, b_ucnt}), 32'd0);
        check("b_midreset_in_ready", 32'(b_in_ready), 32'd1);
        q_b.delete();
        @(posedge clock); #1;
        b_resetn = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clock); #1;
        send_b(12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
        drain_b();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
